// File: rtl/key_expansion_unit.sv
// Sequential AES-128 key schedule: expands key_in into 11 round keys, one per clock.
// Optional KEYEXP_ZEROIZE_EN clears stale slots on start and the working key after done.
module key_expansion_unit #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic                              start,
  input  logic [KEY_W-1:0]                  key_in,
  output logic                              busy,
  output logic                              done,
  output logic                              key_valid,
  output logic [(NUM_ROUNDS+1)*KEY_W-1:0]   round_keys
);

  // state  | meaning
  // IDLE   | waiting for start; round_keys held
  // EXPAND | generating round key round_q, one per cycle
  typedef enum logic {S_IDLE = 1'b0, S_EXPAND = 1'b1} state_t;

  localparam int RK_W = (NUM_ROUNDS + 1) * KEY_W;

  state_t             state_q, state_d;
  logic [3:0]         round_q, round_d;
  logic [7:0]         rcon_q, rcon_d;
  logic [KEY_W-1:0]   work_q, work_d;
  logic [RK_W-1:0]    rk_q, rk_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;

  logic [31:0]        temp;
  logic [KEY_W-1:0]   next_key;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 via x^127 squared; naturally maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) begin
      r = gf_mul(gf_mul(r, r), a);
    end
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  always_comb begin
    logic [31:0] nw0, nw1, nw2, nw3;
    temp     = sub_word({work_q[23:0], work_q[31:24]}) ^ {rcon_q, 24'h0};
    nw0      = work_q[127:96] ^ temp;
    nw1      = work_q[95:64]  ^ nw0;
    nw2      = work_q[63:32]  ^ nw1;
    nw3      = work_q[31:0]   ^ nw2;
    next_key = {nw0, nw1, nw2, nw3};
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    work_d  = work_q;
    rk_d    = rk_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rk_d[KEY_W-1:0] = key_in;
`ifdef KEYEXP_ZEROIZE_EN
          for (int r = 1; r <= NUM_ROUNDS; r++) begin
            rk_d[r*KEY_W +: KEY_W] = '0;
          end
`endif
          work_d  = key_in;
          round_d = 4'd1;
          rcon_d  = 8'h01;
          valid_d = 1'b0;
          state_d = S_EXPAND;
        end
      end
      S_EXPAND: begin
        for (int r = 1; r <= NUM_ROUNDS; r++) begin
          if (round_q == 4'(r)) rk_d[r*KEY_W +: KEY_W] = next_key;
        end
        work_d = next_key;
        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        if (round_q == 4'(NUM_ROUNDS)) begin
          state_d = S_IDLE;
          round_d = 4'd0;
          valid_d = 1'b1;
          done_d  = 1'b1;
`ifdef KEYEXP_ZEROIZE_EN
          work_d  = '0;
`endif
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      round_q <= '0;
      rcon_q  <= '0;
      work_q  <= '0;
      rk_q    <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      work_q  <= work_d;
      rk_q    <= rk_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign busy       = (state_q == S_EXPAND);
  assign done       = done_q;
  assign key_valid  = valid_q;
  assign round_keys = rk_q;

endmodule

// File: tb/tb_key_expansion_unit.sv
// Bench for key_expansion_unit: FIPS-197 vectors plus random keys against a word-level reference.
module tb_key_expansion_unit;

  logic          clk;
  logic          n_rst;
  logic          start;
  logic [127:0]  key_in;
  logic          busy;
  logic          done;
  logic          key_valid;
  logic [1407:0] round_keys;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_S1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_S10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_S1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_S10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [7:0] RCON_TAB [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  logic [7:0] sbox_tab [256];

  key_expansion_unit dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .key_valid  (key_valid),
    .round_keys (round_keys)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Carry-less product then polynomial reduction.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tab[x] = s;
    end
  endtask

  function automatic logic [1407:0] model_ks(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [1407:0] rk;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {RCON_TAB[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Key is scrambled right after acceptance; it must have no effect.
  task automatic accept(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    cyc();
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(input int inj, output int lat, output int bcnt);
    lat  = -1;
    bcnt = busy ? 1 : 0;
    for (int n = 1; n <= 20; n++) begin
      if (n == inj) begin
        start  = 1'b1;
        key_in = '0;
      end
      cyc();
      start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
      if (busy) bcnt++;
    end
    if (lat < 0) chk("done_timeout", 128'(lat), 128'd10);
  endtask

  task automatic check_all(input string tag, input logic [127:0] k);
    logic [1407:0] exp;
    exp = model_ks(k);
    for (int r = 0; r < 11; r++)
      chk($sformatf("%s_slot%0d", tag, r), round_keys[r*128 +: 128], exp[r*128 +: 128]);
    chk({tag, "_valid"}, 128'(key_valid), 128'd1);
  endtask

  initial begin
    int lat;
    int bcnt;
    logic done_seen;
    logic [127:0] k;

    n_rst  = 1'b0;
    start  = 1'b0;
    key_in = '0;
    build_sbox();
    repeat (3) cyc();
    chk("rst_rk", 128'(round_keys != '0), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_valid", 128'(key_valid), 128'd0);
    n_rst = 1'b1;

    done_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (done) done_seen = 1'b1;
    end
    chk("idle_rk", 128'(round_keys != '0), 128'd0);
    chk("idle_valid", 128'(key_valid), 128'd0);
    chk("idle_busy", 128'(busy), 128'd0);
    chk("idle_done", 128'(done_seen), 128'd0);

    accept(FIPS_KEY);
    chk("fips_busy0", 128'(busy), 128'd1);
    wait_done(0, lat, bcnt);
    chk("fips_lat", 128'(lat), 128'd10);
    chk("fips_busycnt", 128'(bcnt), 128'd10);
    chk("fips_s1", round_keys[255:128], FIPS_S1);
    chk("fips_s10", round_keys[1407:1280], FIPS_S10);
    check_all("fips", FIPS_KEY);
    chk("fips_busy_end", 128'(busy), 128'd0);
    cyc();
    chk("fips_done_pulse", 128'(done), 128'd0);
    chk("fips_valid_hold", 128'(key_valid), 128'd1);

    accept('0);
    chk("zk_slot0", round_keys[127:0], 128'd0);
    chk("zk_valid_drop", 128'(key_valid), 128'd0);
`ifdef KEYEXP_ZEROIZE_EN
    for (int r = 1; r < 11; r++)
      chk($sformatf("zeroize_slot%0d", r), round_keys[r*128 +: 128], 128'd0);
`else
    chk("stale_s10", round_keys[1407:1280], FIPS_S10);
`endif
    wait_done(0, lat, bcnt);
    chk("zk_lat", 128'(lat), 128'd10);
    chk("zk_s1", round_keys[255:128], ZERO_S1);
    chk("zk_s10", round_keys[1407:1280], ZERO_S10);
    cyc();

    accept(FIPS_KEY);
    wait_done(4, lat, bcnt);
    chk("ign_lat", 128'(lat), 128'd10);
    chk("ign_s10", round_keys[1407:1280], FIPS_S10);

    // done is high here: a start now must be accepted immediately.
    k = {$urandom, $urandom, $urandom, $urandom};
    accept(k);
    chk("b2b_valid", 128'(key_valid), 128'd0);
    chk("b2b_busy", 128'(busy), 128'd1);
    chk("b2b_slot0", round_keys[127:0], k);
    wait_done(0, lat, bcnt);
    chk("b2b_lat", 128'(lat), 128'd10);
    check_all("b2b", k);

    for (int t = 0; t < 4; t++) begin
      cyc();
      k = {$urandom, $urandom, $urandom, $urandom};
      accept(k);
      wait_done(0, lat, bcnt);
      chk($sformatf("rnd%0d_lat", t), 128'(lat), 128'd10);
      check_all($sformatf("rnd%0d", t), k);
    end

    cyc();
    accept(FIPS_KEY);
    repeat (4) cyc();
    n_rst = 1'b0;
    #1;
    chk("mid_rst_rk", 128'(round_keys != '0), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_valid", 128'(key_valid), 128'd0);
    chk("mid_rst_done", 128'(done), 128'd0);
    cyc();
    n_rst = 1'b1;
    cyc();
    k = {$urandom, $urandom, $urandom, $urandom};
    accept(k);
    wait_done(0, lat, bcnt);
    chk("post_rst_lat", 128'(lat), 128'd10);
    check_all("post_rst", k);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
